// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, default width and counter sizing.
package arith_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

    // The step counter has to reach WIDTH, hence WIDTH+1 distinct values.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand and result handshakes of the sequential divider.
interface seq_restoring_divider_if
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider_restoring_step.sv
// One restoring-division step: shift in the next dividend bit, subtract, keep or restore.
module restoring_step
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted = {r[WIDTH-1:0], shift_in};
        // One guard bit above the shifted remainder makes the borrow the sign.
        trial   = {r, shift_in} - {2'b00, divisor};
        q_bit   = ~trial[WIDTH+1];
        r_next  = q_bit ? trial[WIDTH:0] : shifted;
    end
endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER_ZERO_DETECT_EN to short-circuit a zero divisor straight to DONE with div_by_zero.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic                   clk,
    input logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d, step_r;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             step_bit;
    logic             idle, done;

    restoring_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r        (r_q),
        .shift_in (q_q[WIDTH-1]),
        .divisor  (dvs_q),
        .r_next   (step_r),
        .q_bit    (step_bit)
    );

    assign idle          = (state_q == IDLE);
    assign done          = (state_q == DONE);
    assign bus.in_ready  = idle;
    assign bus.out_valid = done;
    assign bus.quotient  = done ? q_q : '0;
    assign bus.remainder = done ? r_q[WIDTH-1:0] : '0;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvs_d   = bus.divisor;
                    q_d     = bus.dividend;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef DIVIDER_ZERO_DETECT_EN
                    if (bus.divisor == '0) begin
                        q_d     = '1;
                        r_d     = {1'b0, bus.dividend};
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                r_d   = step_r;
                q_d   = {q_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DIVIDER_ZERO_DETECT_EN
    logic dbz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dbz_q <= 1'b0;
        end else if (idle && bus.in_valid) begin
            dbz_q <= (bus.divisor == '0);
        end else if (done && bus.out_ready) begin
            dbz_q <= 1'b0;
        end
    end

    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: arithmetic/timing model plus directed literals.
module tb_seq_restoring_divider;
    localparam int W = 8;
`ifdef DIVIDER_ZERO_DETECT_EN
    localparam int ZD_LAT = 0;
    localparam logic ZD_FLAG = 1'b1;
`else
    localparam int ZD_LAT = W;
    localparam logic ZD_FLAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_restoring_divider_if #(.WIDTH(W)) dut_if ();

    seq_restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at t=%0t", name, $time);
    endtask

    // Model: one division in flight, result = a/b, a%b (b==0 -> all ones, a),
    // out_valid once the latency has elapsed since the accept edge.
    int         cyc = 0;
    int         acc_cyc = 0;
    bit         inflight = 1'b0;
    int         m_lat = W;
    logic [7:0] m_q = '0, m_r = '0;
    logic       m_dbz = 1'b0;
    bit         m_acc = 1'b0, m_hs = 1'b0, m_rst = 1'b1;
    logic [7:0] m_a = '0, m_b = '0;
    bit         ov_e;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_rst) begin
            inflight = 1'b0;
        end else if (m_acc) begin
            inflight = 1'b1;
            acc_cyc  = cyc;
            if (m_b == 0) begin
                m_q   = 8'hFF;
                m_r   = m_a;
                m_dbz = ZD_FLAG;
                m_lat = ZD_LAT;
            end else begin
                m_q   = m_a / m_b;
                m_r   = m_a % m_b;
                m_dbz = 1'b0;
                m_lat = W;
            end
        end else if (m_hs) begin
            inflight = 1'b0;
        end
    end

    always @(negedge clk) begin
        ov_e = inflight && ((cyc - acc_cyc) >= m_lat);
        if (!rst) begin
            chk("in_ready", dut_if.in_ready, !inflight);
            chk("out_valid", dut_if.out_valid, ov_e);
            chk("quotient", dut_if.quotient, ov_e ? m_q : 8'd0);
            chk("remainder", dut_if.remainder, ov_e ? m_r : 8'd0);
            chk("div_by_zero", dut_if.div_by_zero, ov_e ? m_dbz : 1'b0);
        end
        m_rst = rst;
        m_acc = !rst && dut_if.in_valid && !inflight;
        m_hs  = !rst && ov_e && dut_if.out_ready;
        m_a   = dut_if.dividend;
        m_b   = dut_if.divisor;
    end

    int acc_edge = 0;
    int hs_edge  = 0;
    int lat;

    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        while (!dut_if.in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) fail_timeout("wait_in_ready");
        dut_if.in_valid = 1'b1;
        dut_if.dividend = a;
        dut_if.divisor  = b;
        @(posedge clk); #1;
        acc_edge = cyc;
        dut_if.in_valid = 1'b0;
        dut_if.dividend = 8'($urandom);
        dut_if.divisor  = 8'($urandom);
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (!dut_if.out_valid && l < 50) begin
            @(posedge clk); #1;
            l++;
        end
        if (l >= 50) fail_timeout("wait_out_valid");
    endtask

    logic [7:0] ta [4] = '{8'd200, 8'd255, 8'd5, 8'd0};
    logic [7:0] tb [4] = '{8'd7,   8'd1,   8'd9, 8'd3};
    logic [7:0] tq [4] = '{8'd28,  8'd255, 8'd0, 8'd0};
    logic [7:0] tr [4] = '{8'd4,   8'd0,   8'd5, 8'd0};

    initial begin
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b0;
        dut_if.dividend  = '0;
        dut_if.divisor   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", dut_if.in_ready, 1);
        chk("rst_out_valid", dut_if.out_valid, 0);
        chk("rst_quotient", dut_if.quotient, 0);
        chk("rst_remainder", dut_if.remainder, 0);
        chk("rst_dbz", dut_if.div_by_zero, 0);

        // Back-to-back directed vectors with out_ready tied high.
        dut_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(ta[i], tb[i]);
            if (i > 0) chk("accept_gap", acc_edge - hs_edge, 1);
            wait_valid(lat);
            chk("latency", lat, 8);
            chk("dir_quotient", dut_if.quotient, tq[i]);
            chk("dir_remainder", dut_if.remainder, tr[i]);
            @(posedge clk); #1;
            hs_edge = cyc;
            chk("idle_after_hs", dut_if.in_ready, 1);
        end

        // Zero divisor.
        drive(8'd100, 8'd0);
        wait_valid(lat);
        chk("zd_latency", lat, ZD_LAT);
        chk("zd_quotient", dut_if.quotient, 255);
        chk("zd_remainder", dut_if.remainder, 100);
        chk("zd_flag", dut_if.div_by_zero, ZD_FLAG);
        @(posedge clk); #1;
        chk("zd_flag_clear", dut_if.div_by_zero, 0);

        // Backpressure with in_valid toggling while the result is held.
        dut_if.out_ready = 1'b0;
        drive(8'd77, 8'd5);
        wait_valid(lat);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", dut_if.out_valid, 1);
            chk("bp_quotient", dut_if.quotient, 15);
            chk("bp_remainder", dut_if.remainder, 2);
            dut_if.in_valid = ~dut_if.in_valid;
            dut_if.dividend = 8'd1;
            dut_if.divisor  = 8'd1;
            @(posedge clk); #1;
        end
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", dut_if.in_ready, 1);

        // Reset sampled at the third BUSY step.
        drive(8'd250, 8'd6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", dut_if.in_ready, 1);
        chk("abort_out_valid", dut_if.out_valid, 0);
        chk("abort_quotient", dut_if.quotient, 0);
        chk("abort_remainder", dut_if.remainder, 0);
        drive(8'd9, 8'd3);
        wait_valid(lat);
        chk("post_abort_latency", lat, 8);
        chk("post_abort_quotient", dut_if.quotient, 3);
        chk("post_abort_remainder", dut_if.remainder, 0);
        @(posedge clk); #1;

        // Random operands with idle gaps and random out_ready; checked by the model.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] a, b;
            int t;
            bit hs;
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            drive(a, b);
            t  = 0;
            hs = 1'b0;
            while (!hs && t < 200) begin
                dut_if.out_ready = 1'($urandom_range(0, 1));
                hs = dut_if.out_valid && dut_if.out_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!hs) fail_timeout("random_handshake");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
